jtag_ir_dr_ctrl: RTL and testbench

TAP-side instruction/data register controller. It consumes the TAP state from the TAP FSM and performs the IEEE 1149.1 capture/shift/update sequencing of the instruction register (IR) and the selected data register (DR): IDCODE, BYPASS or a USER register toward the AXI bridge. It selects the TDO source and raises a one-cycle update strobe toward the user side.

---
 rtl/jtag_ir_dr_ctrl_if.sv | 68 ++++++
 rtl/jtag_ir_dr_ctrl.sv | 132 +++++++++++++
 tb/tb_jtag_ir_dr_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_ir_dr_ctrl_if.sv
// TAP state encoding shared by the TAP FSM, this controller and its bench,
// plus the signal bundle between the TAP side and the IR/DR controller.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_ctrl_fsm_t;

endpackage

interface jtag_ir_dr_ctrl_if #(
    parameter int unsigned IR_WIDTH = 4,
    parameter int unsigned DR_WIDTH = 40
) ();
    import jtag_tap_pkg::*;

    tap_ctrl_fsm_t         tap_state;
    logic                  tdi;
    logic                  tdo;
    logic                  tdo_en;
    logic [IR_WIDTH-1:0]   ir_q;
    logic [DR_WIDTH-1:0]   user_capture_data;
    logic [DR_WIDTH-1:0]   user_data;
    logic                  user_update;
    logic                  user_capture;

    // TAP / user side: drives state, serial input and capture data
    modport master (
        output tap_state,
        output tdi,
        output user_capture_data,
        input  tdo,
        input  tdo_en,
        input  ir_q,
        input  user_data,
        input  user_update,
        input  user_capture
    );

    // IR/DR controller side
    modport slave (
        input  tap_state,
        input  tdi,
        input  user_capture_data,
        output tdo,
        output tdo_en,
        output ir_q,
        output user_data,
        output user_update,
        output user_capture
    );

endinterface

// File: rtl/jtag_ir_dr_ctrl.sv
// IEEE 1149.1 instruction/data register sequencing: IR, IDCODE, BYPASS and a
// USER DR toward the AXI bridge, with TDO source selection and user strobes.
module jtag_ir_dr_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int unsigned          IR_WIDTH     = 4,
    parameter int unsigned          DR_WIDTH     = 40,
    parameter logic [31:0]          IDCODE_VAL   = 32'h1BEEF001,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0]  INSTR_USER   = IR_WIDTH'(4'hA)
) (
    input  logic              tck,
    input  logic              trst,
    jtag_ir_dr_ctrl_if.slave  bus
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

    tap_ctrl_fsm_t          tap_state;
    logic                   tdi;
    dr_sel_t                dr_sel;

    logic [IR_WIDTH-1:0]    ir_q;
    logic [IR_WIDTH-1:0]    ir_shift;
    logic [31:0]            idcode_shift;
    logic                   bypass_ff;
    logic [DR_WIDTH-1:0]    user_shift;
    logic [DR_WIDTH-1:0]    user_data;
    logic                   user_update;
    logic                   user_capture;
    logic                   tdo;

    assign tap_state = bus.tap_state;
    assign tdi       = bus.tdi;

    // ir_q only moves at UPDATE_IR / TEST_LOGIC_RESET, so a DR scan always
    // sees the instruction that was active at its CAPTURE_DR.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == INSTR_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == INSTR_USER) begin
            dr_sel = DR_USER;
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_q     <= INSTR_IDCODE;
            ir_shift <= '0;
        end else begin
            case (tap_state)
                TEST_LOGIC_RESET: ir_q     <= INSTR_IDCODE;
                CAPTURE_IR:       ir_shift <= IR_CAPTURE;
                SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_q     <= ir_shift;
                default:          ;
            endcase
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            idcode_shift <= IDCODE_VAL;
            bypass_ff    <= 1'b0;
            user_shift   <= '0;
            user_data    <= '0;
        end else begin
            case (tap_state)
                CAPTURE_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift <= IDCODE_VAL;
                        DR_USER:   user_shift   <= bus.user_capture_data;
                        default:   bypass_ff    <= 1'b0;
                    endcase
                end
                SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift <= {tdi, idcode_shift[31:1]};
                        DR_USER:   user_shift   <= {tdi, user_shift[DR_WIDTH-1:1]};
                        default:   bypass_ff    <= tdi;
                    endcase
                end
                UPDATE_DR: begin
                    if (dr_sel == DR_USER) begin
                        user_data <= user_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are recomputed every edge, so each lasts exactly one tck and
    // the two can never coincide (distinct source states).
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_capture <= 1'b0;
            user_update  <= 1'b0;
        end else begin
            user_capture <= (tap_state == CAPTURE_DR) && (dr_sel == DR_USER);
            user_update  <= (tap_state == UPDATE_DR)  && (dr_sel == DR_USER);
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (tap_state == SHIFT_IR) begin
            tdo = ir_shift[0];
        end else if (tap_state == SHIFT_DR) begin
            case (dr_sel)
                DR_IDCODE: tdo = idcode_shift[0];
                DR_USER:   tdo = user_shift[0];
                default:   tdo = bypass_ff;
            endcase
        end
    end

    assign bus.tdo          = tdo;
    assign bus.tdo_en       = (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
    assign bus.ir_q         = ir_q;
    assign bus.user_data    = user_data;
    assign bus.user_update  = user_update;
    assign bus.user_capture = user_capture;

endmodule

// File: tb/tb_jtag_ir_dr_ctrl.sv
// Bench for jtag_ir_dr_ctrl: vector table, directed scans and a random TAP walk
// checked against a register-level behavioural model.
module tb_jtag_ir_dr_ctrl;
    import jtag_tap_pkg::*;

    localparam int IRW = 4;
    localparam int DRW = 40;
    localparam logic [31:0] IDC = 32'h1BEEF001;

    logic tck = 1'b0;
    logic trst;

    jtag_ir_dr_ctrl_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus ();

    jtag_ir_dr_ctrl #(
        .IR_WIDTH    (IRW),
        .DR_WIDTH    (DRW),
        .IDCODE_VAL  (IDC),
        .INSTR_IDCODE(4'h1),
        .INSTR_USER  (4'hA)
    ) dut (
        .tck (tck),
        .trst(trst),
        .bus (bus)
    );

    always #5 tck = ~tck;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    int n_total = 0;
    int n_pass  = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;
    int en_cnt  = 0;
    logic last_tdo, last_en;

    // ---------------- behavioural model ----------------
    logic [IRW-1:0] m_ir, m_irs;
    logic [31:0]    m_id;
    logic           m_byp;
    logic [DRW-1:0] m_us, m_ud;
    logic           m_upd, m_cap;

    function automatic int sel_kind();  // 0 bypass, 1 idcode, 2 user
        if (m_ir == 4'h1) return 1;
        if (m_ir == 4'hA) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ir = 4'h1; m_irs = '0; m_id = IDC; m_byp = 1'b0;
        m_us = '0; m_ud = '0; m_upd = 1'b0; m_cap = 1'b0;
    endtask

    function automatic logic model_tdo(tap_ctrl_fsm_t s);
        if (s == SHIFT_IR) return m_irs[0];
        if (s == SHIFT_DR) begin
            case (sel_kind())
                1:       return m_id[0];
                2:       return m_us[0];
                default: return m_byp;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic model_edge(tap_ctrl_fsm_t s, logic d, logic [DRW-1:0] cap_data);
        int k;
        logic nu, nc;
        k = sel_kind();
        nu = 1'b0; nc = 1'b0;
        if (s == TEST_LOGIC_RESET) m_ir = 4'h1;
        if (s == CAPTURE_IR)       m_irs = 4'd1;
        if (s == SHIFT_IR)         m_irs = (m_irs >> 1) + (d ? 4'd8 : 4'd0);
        if (s == UPDATE_IR)        m_ir = m_irs;
        if (s == CAPTURE_DR) begin
            if (k == 1) m_id = IDC;
            else if (k == 2) begin m_us = cap_data; nc = 1'b1; end
            else m_byp = 1'b0;
        end
        if (s == SHIFT_DR) begin
            if (k == 1) m_id = (m_id >> 1) + (d ? 32'h8000_0000 : 32'd0);
            else if (k == 2) m_us = (m_us >> 1) + (d ? (40'd1 << 39) : 40'd0);
            else m_byp = d;
        end
        if (s == UPDATE_DR && k == 2) begin m_ud = m_us; nu = 1'b1; end
        m_upd = nu; m_cap = nc;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Entered and left at a negedge; one TAP state per tck.
    task automatic step(input tap_ctrl_fsm_t s, input logic d);
        bus.tap_state = s;
        bus.tdi       = d;
        #1;
        last_tdo = bus.tdo;
        last_en  = bus.tdo_en;
        if (bus.tdo_en) en_cnt++;
        check("tdo", 64'(bus.tdo), 64'(model_tdo(s)));
        check("tdo_en", 64'(bus.tdo_en), 64'(s == SHIFT_IR || s == SHIFT_DR));
        @(posedge tck);
        model_edge(s, d, bus.user_capture_data);
        #1;
        check("ir_q", 64'(bus.ir_q), 64'(m_ir));
        check("user_data", 64'(bus.user_data), 64'(m_ud));
        check("user_update", 64'(bus.user_update), 64'(m_upd));
        check("user_capture", 64'(bus.user_capture), 64'(m_cap));
        if (bus.user_capture) cap_cnt++;
        if (bus.user_update)  upd_cnt++;
        @(negedge tck);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ir_q"}, 64'(bus.ir_q), 64'h1);
        check({tag, "_user_data"}, 64'(bus.user_data), 64'h0);
        check({tag, "_user_update"}, 64'(bus.user_update), 64'h0);
        check({tag, "_user_capture"}, 64'(bus.user_capture), 64'h0);
        check({tag, "_tdo"}, 64'(bus.tdo), 64'h0);
        check({tag, "_tdo_en"}, 64'(bus.tdo_en), 64'h0);
    endtask

    task automatic do_reset();
        trst = 1'b1;
        bus.tap_state = TEST_LOGIC_RESET;
        bus.tdi = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge tck);
        trst = 1'b0;
    endtask

    task automatic scan_ir(input logic [IRW-1:0] v);
        step(SELECT_DR_SCAN, 1'b0);
        step(SELECT_IR_SCAN, 1'b0);
        step(CAPTURE_IR, 1'b0);
        for (int i = 0; i < IRW; i++) step(SHIFT_IR, v[i]);
        step(EXIT1_IR, 1'b0);
        step(UPDATE_IR, 1'b0);
        step(RUN_TEST_IDLE, 1'b0);
        check("scan_ir_result", 64'(bus.ir_q), 64'(v));
    endtask

    function automatic tap_ctrl_fsm_t tap_next(tap_ctrl_fsm_t s, logic tms);
        case (s)
            TEST_LOGIC_RESET: if (tms) return TEST_LOGIC_RESET; else return RUN_TEST_IDLE;
            RUN_TEST_IDLE:    if (tms) return SELECT_DR_SCAN;   else return RUN_TEST_IDLE;
            SELECT_DR_SCAN:   if (tms) return SELECT_IR_SCAN;   else return CAPTURE_DR;
            CAPTURE_DR:       if (tms) return EXIT1_DR;         else return SHIFT_DR;
            SHIFT_DR:         if (tms) return EXIT1_DR;         else return SHIFT_DR;
            EXIT1_DR:         if (tms) return UPDATE_DR;        else return PAUSE_DR;
            PAUSE_DR:         if (tms) return EXIT2_DR;         else return PAUSE_DR;
            EXIT2_DR:         if (tms) return UPDATE_DR;        else return SHIFT_DR;
            UPDATE_DR:        if (tms) return SELECT_DR_SCAN;   else return RUN_TEST_IDLE;
            SELECT_IR_SCAN:   if (tms) return TEST_LOGIC_RESET; else return CAPTURE_IR;
            CAPTURE_IR:       if (tms) return EXIT1_IR;         else return SHIFT_IR;
            SHIFT_IR:         if (tms) return EXIT1_IR;         else return SHIFT_IR;
            EXIT1_IR:         if (tms) return UPDATE_IR;        else return PAUSE_IR;
            PAUSE_IR:         if (tms) return EXIT2_IR;         else return PAUSE_IR;
            EXIT2_IR:         if (tms) return UPDATE_IR;        else return SHIFT_IR;
            default:          if (tms) return SELECT_DR_SCAN;   else return RUN_TEST_IDLE;
        endcase
    endfunction

    typedef struct {
        tap_ctrl_fsm_t st;
        logic          tdi;
        logic          exp_tdo;
        logic          exp_en;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [31:0]    got32;
        logic [DRW-1:0] got40, data;
        tap_ctrl_fsm_t  st;
        logic           tms;

        // IR scan of all-ones (BYPASS), then a 3-bit BYPASS DR scan
        vt[0]  = '{RUN_TEST_IDLE,  1'b0, 1'b0, 1'b0};
        vt[1]  = '{SELECT_DR_SCAN, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{SELECT_IR_SCAN, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{CAPTURE_IR,     1'b0, 1'b0, 1'b0};
        vt[4]  = '{SHIFT_IR,       1'b1, 1'b1, 1'b1};
        vt[5]  = '{SHIFT_IR,       1'b1, 1'b0, 1'b1};
        vt[6]  = '{SHIFT_IR,       1'b1, 1'b0, 1'b1};
        vt[7]  = '{SHIFT_IR,       1'b1, 1'b0, 1'b1};
        vt[8]  = '{EXIT1_IR,       1'b0, 1'b0, 1'b0};
        vt[9]  = '{UPDATE_IR,      1'b0, 1'b0, 1'b0};
        vt[10] = '{SELECT_DR_SCAN, 1'b0, 1'b0, 1'b0};
        vt[11] = '{CAPTURE_DR,     1'b0, 1'b0, 1'b0};
        vt[12] = '{SHIFT_DR,       1'b1, 1'b0, 1'b1};
        vt[13] = '{SHIFT_DR,       1'b0, 1'b1, 1'b1};
        vt[14] = '{SHIFT_DR,       1'b1, 1'b0, 1'b1};
        vt[15] = '{EXIT1_DR,       1'b0, 1'b0, 1'b0};
        vt[16] = '{UPDATE_DR,      1'b0, 1'b0, 1'b0};
        vt[17] = '{RUN_TEST_IDLE,  1'b0, 1'b0, 1'b0};

        bus.user_capture_data = '0;
        trst = 1'b1;
        @(negedge tck);
        do_reset();

        // IDCODE is selected out of reset
        step(RUN_TEST_IDLE, 1'b0);
        step(SELECT_DR_SCAN, 1'b0);
        step(CAPTURE_DR, 1'b0);
        en_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(SHIFT_DR, 1'b0);
            got32[i] = last_tdo;
        end
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        step(RUN_TEST_IDLE, 1'b0);
        check("idcode_stream", 64'(got32), 64'(IDC));
        check("idcode_tdo_en_cycles", 64'(en_cnt), 64'd32);

        for (int i = 0; i < 18; i++) begin
            step(vt[i].st, vt[i].tdi);
            check($sformatf("vec%0d_tdo", i), 64'(last_tdo), 64'(vt[i].exp_tdo));
            check($sformatf("vec%0d_tdo_en", i), 64'(last_en), 64'(vt[i].exp_en));
        end
        check("vec_ir_bypass", 64'(bus.ir_q), 64'hF);

        // USER scan: capture, 40-bit shift, update strobe one cycle later
        scan_ir(4'hA);
        bus.user_capture_data = 40'h12_3456_789A;
        data = 40'hA5_A5A5_A5A5;
        cap_cnt = 0; upd_cnt = 0;
        step(SELECT_DR_SCAN, 1'b0);
        step(CAPTURE_DR, 1'b0);
        check("user_capture_pulse", 64'(bus.user_capture), 64'h1);
        for (int i = 0; i < DRW; i++) begin
            step(SHIFT_DR, data[i]);
            got40[i] = last_tdo;
        end
        step(EXIT1_DR, 1'b0);
        check("user_update_early", 64'(bus.user_update), 64'h0);
        step(UPDATE_DR, 1'b0);
        check("user_update_pulse", 64'(bus.user_update), 64'h1);
        check("user_data_a5", 64'(bus.user_data), 64'hA5_A5A5_A5A5);
        step(RUN_TEST_IDLE, 1'b0);
        check("user_update_clears", 64'(bus.user_update), 64'h0);
        check("user_capture_stream", 64'(got40), 64'h12_3456_789A);
        check("user_capture_count", 64'(cap_cnt), 64'd1);
        check("user_update_count", 64'(upd_cnt), 64'd1);

        // USER scan split by a pause: one contiguous 40-bit stream
        data = {8'($urandom), 32'($urandom)};
        bus.user_capture_data = {8'($urandom), 32'($urandom)};
        cap_cnt = 0;
        step(SELECT_DR_SCAN, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 20; i++) step(SHIFT_DR, data[i]);
        step(EXIT1_DR, 1'b0);
        for (int i = 0; i < 5; i++) step(PAUSE_DR, 1'b0);
        step(EXIT2_DR, 1'b0);
        for (int i = 20; i < 40; i++) step(SHIFT_DR, data[i]);
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        step(RUN_TEST_IDLE, 1'b0);
        check("pause_user_data", 64'(bus.user_data), 64'(data));
        check("pause_capture_count", 64'(cap_cnt), 64'd1);

        // TEST_LOGIC_RESET restores IDCODE without trst
        step(SELECT_DR_SCAN, 1'b1);
        step(SELECT_IR_SCAN, 1'b1);
        step(TEST_LOGIC_RESET, 1'b0);
        check("tlr_ir_q", 64'(bus.ir_q), 64'h1);
        step(RUN_TEST_IDLE, 1'b0);
        step(SELECT_DR_SCAN, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(SHIFT_DR, 1'b1);
            got32[i] = last_tdo;
        end
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        step(RUN_TEST_IDLE, 1'b0);
        check("tlr_idcode_stream", 64'(got32), 64'(IDC));

        // trst mid USER shift takes effect before the next tck edge
        scan_ir(4'hA);
        bus.user_capture_data = 40'hFF_0000_FFFF;
        step(SELECT_DR_SCAN, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 10; i++) step(SHIFT_DR, 1'b1);
        bus.tap_state = SHIFT_DR;
        #2;
        trst = 1'b1;
        bus.tap_state = TEST_LOGIC_RESET;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge tck);
        trst = 1'b0;

        // Random legal TAP walks against the model
        for (int blk = 0; blk < 30; blk++) begin
            logic [IRW-1:0] op;
            case ($urandom_range(0, 3))
                0:       op = 4'h1;
                1:       op = 4'hA;
                2:       op = 4'hF;
                default: op = 4'($urandom);
            endcase
            step(RUN_TEST_IDLE, 1'b0);
            scan_ir(op);
            st = RUN_TEST_IDLE;
            for (int c = 0; c < 60; c++) begin
                if (st == SHIFT_DR || st == SHIFT_IR || st == PAUSE_DR || st == PAUSE_IR)
                    tms = ($urandom_range(0, 7) == 0);
                else
                    tms = 1'($urandom_range(0, 1));
                bus.user_capture_data = {8'($urandom), 32'($urandom)};
                step(st, 1'($urandom));
                st = tap_next(st, tms);
            end
            for (int c = 0; c < 5; c++) begin
                step(st, 1'b0);
                st = tap_next(st, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
